// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception status flags and the reorder-buffer slot entry.
package fpnew_pkg;

    // Storage widths of a reorder slot; instances must not exceed them.
    localparam int unsigned FP_WIDTH  = 64;
    localparam int unsigned TAG_WIDTH = 8;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        logic [FP_WIDTH-1:0]  result;
        status_t              status;
        logic                 ext_bit;
        logic [TAG_WIDTH-1:0] tag;
        logic                 allocated;
        logic                 done;
    } reorder_entry_t;

endpackage

// File: rtl/fpnew_result_reorder.sv
// In-order retire buffer for out-of-order opgroup completions.
// Optional same-cycle head bypass enabled by defining FPNEW_REORDER_BYPASS_EN.
module fpnew_result_reorder
    import fpnew_pkg::*;
#(
    parameter int unsigned Width    = 64,
    parameter int unsigned Depth    = 8,
    parameter int unsigned TagWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [TagWidth-1:0]      alloc_tag_i,
    output logic [$clog2(Depth)-1:0] alloc_id_o,
    input  logic                     cpl_valid_i,
    input  logic [$clog2(Depth)-1:0] cpl_id_i,
    input  logic [Width-1:0]         cpl_result_i,
    input  status_t                  cpl_status_i,
    input  logic                     cpl_ext_i,
    output logic                     cpl_err_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [Width-1:0]         result_o,
    output status_t                  status_o,
    output logic                     extension_bit_o,
    output logic [TagWidth-1:0]      tag_o,
    output logic                     busy_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = IdxW + 1;

    reorder_entry_t  slots_q [Depth];
    logic [IdxW-1:0] head_q;
    logic [IdxW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    logic            cpl_err_q;

    reorder_entry_t  head_entry;
    logic            alloc_fire;
    logic            out_fire;
    logic            cpl_legal;
    logic            cpl_write;
    logic            bypass_take;

    assign head_entry    = slots_q[head_q];
    assign alloc_ready_o = (count_q < CntW'(Depth));
    assign alloc_id_o    = tail_q;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign cpl_legal     = cpl_valid_i & slots_q[cpl_id_i].allocated & ~slots_q[cpl_id_i].done;
    assign busy_o        = (count_q != '0);
    assign cpl_err_o     = cpl_err_q;

`ifdef FPNEW_REORDER_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = cpl_legal & (cpl_id_i == head_q);

    always_comb begin
        out_valid_o     = head_entry.allocated & head_entry.done;
        result_o        = Width'(head_entry.result);
        status_o        = head_entry.status;
        extension_bit_o = head_entry.ext_bit;
        tag_o           = TagWidth'(head_entry.tag);
        if (bypass_hit) begin
            out_valid_o     = 1'b1;
            result_o        = cpl_result_i;
            status_o        = cpl_status_i;
            extension_bit_o = cpl_ext_i;
        end
    end

    // A bypassed result taken by the consumer never lands in the slot.
    assign bypass_take = bypass_hit & out_ready_i;
`else
    always_comb begin
        out_valid_o     = head_entry.allocated & head_entry.done;
        result_o        = Width'(head_entry.result);
        status_o        = head_entry.status;
        extension_bit_o = head_entry.ext_bit;
        tag_o           = TagWidth'(head_entry.tag);
    end

    assign bypass_take = 1'b0;
`endif

    assign out_fire  = out_valid_o & out_ready_i;
    assign cpl_write = cpl_legal & ~bypass_take;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                slots_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cpl_err_q <= 1'b0;
        end else begin
            cpl_err_q <= cpl_valid_i & ~cpl_legal & ~flush_i;
            if (flush_i) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    slots_q[i].allocated <= 1'b0;
                    slots_q[i].done      <= 1'b0;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                // Alloc (tail), completion (allocated, not done) and retire
                // (head, done) can never address the same slot in one cycle.
                if (alloc_fire) begin
                    slots_q[tail_q].allocated <= 1'b1;
                    slots_q[tail_q].done      <= 1'b0;
                    slots_q[tail_q].tag       <= TAG_WIDTH'(alloc_tag_i);
                    tail_q                    <= tail_q + 1'b1;
                end
                if (cpl_write) begin
                    slots_q[cpl_id_i].result  <= FP_WIDTH'(cpl_result_i);
                    slots_q[cpl_id_i].status  <= cpl_status_i;
                    slots_q[cpl_id_i].ext_bit <= cpl_ext_i;
                    slots_q[cpl_id_i].done    <= 1'b1;
                end
                if (out_fire) begin
                    slots_q[head_q] <= '0;
                    head_q          <= head_q + 1'b1;
                end
                case ({alloc_fire, out_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Self-checking bench for fpnew_result_reorder: directed scenarios plus a
// randomized run against a queue-based model of outstanding operations.
module tb_fpnew_result_reorder;
    import fpnew_pkg::*;

    localparam int unsigned W  = 64;
    localparam int unsigned D  = 8;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic [2:0]    alloc_id;
    logic          cpl_valid;
    logic [2:0]    cpl_id;
    logic [W-1:0]  cpl_result;
    status_t       cpl_status;
    logic          cpl_ext;
    logic          cpl_err;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    status_t       status;
    logic          ext_bit;
    logic [TW-1:0] tag;
    logic          busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    fpnew_result_reorder #(.Width(W), .Depth(D), .TagWidth(TW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .alloc_valid_i  (alloc_valid),
        .alloc_ready_o  (alloc_ready),
        .alloc_tag_i    (alloc_tag),
        .alloc_id_o     (alloc_id),
        .cpl_valid_i    (cpl_valid),
        .cpl_id_i       (cpl_id),
        .cpl_result_i   (cpl_result),
        .cpl_status_i   (cpl_status),
        .cpl_ext_i      (cpl_ext),
        .cpl_err_o      (cpl_err),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result),
        .status_o       (status),
        .extension_bit_o(ext_bit),
        .tag_o          (tag),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Model: outstanding operations in allocation order; front is the oldest.
    typedef struct {
        int unsigned   id;
        logic [TW-1:0] tag;
        bit            done;
        logic [W-1:0]  res;
        logic [4:0]    st;
        logic          ext;
    } op_t;

    op_t         mq[$];
    int unsigned m_next;
    bit          m_err;

    function automatic int find_op(int unsigned id);
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].id == id) return k;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_next = 0;
        m_err  = 0;
    endtask

    task automatic idle();
        flush       = 0;
        alloc_valid = 0;
        alloc_tag   = '0;
        cpl_valid   = 0;
        cpl_id      = '0;
        cpl_result  = '0;
        cpl_status  = '0;
        cpl_ext     = 0;
        out_ready   = 0;
    endtask

    // Advance the model with the current inputs, then one clock cycle.
    task automatic tick();
        bit  pop, push, err, byp;
        int  k;
        op_t o;
        pop = 0; byp = 0; err = 0;
        if (mq.size() > 0 && out_ready) begin
            if (mq[0].done) pop = 1;
`ifdef FPNEW_REORDER_BYPASS_EN
            else if (cpl_valid && int'(cpl_id) == mq[0].id) begin
                pop = 1;
                byp = 1;
            end
`endif
        end
        push = (mq.size() < D) && alloc_valid;
        if (flush) begin
            mq.delete();
            m_next = 0;
        end else begin
            if (cpl_valid) begin
                k = find_op(int'(cpl_id));
                if (k < 0 || mq[k].done) err = 1;
                else if (!byp) begin
                    o      = mq[k];
                    o.done = 1;
                    o.res  = cpl_result;
                    o.st   = cpl_status;
                    o.ext  = cpl_ext;
                    mq[k]  = o;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                o.id   = m_next;
                o.tag  = alloc_tag;
                o.done = 0;
                o.res  = '0;
                o.st   = '0;
                o.ext  = 0;
                mq.push_back(o);
                m_next = (m_next + 1) % D;
            end
        end
        m_err = err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
        checks++; if (alloc_id !== 3'd0) begin errors++; $display("FAIL reset_alloc_id: got %0d expected 0", alloc_id); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL reset_cpl_err: got %0b expected 0", cpl_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (result !== '0 || tag !== '0 || status !== '0 || ext_bit !== 1'b0) begin
            errors++; $display("FAIL reset_payload: got %0h/%0h/%0h/%0b expected all 0", result, tag, status, ext_bit);
        end
    endtask

    task automatic test_in_order();
        logic [W-1:0] r[3];
        for (int i = 0; i < 3; i++) r[i] = {$urandom, $urandom};
        idle();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1;
            alloc_tag   = 8'h10 + 8'(i);
            #1;
            checks++; if (alloc_id !== 3'(i)) begin errors++; $display("FAIL order_alloc_id: got %0d expected %0d", alloc_id, i); end
            tick();
        end
        idle();
        cpl_valid = 1; cpl_id = 3'd2; cpl_result = r[2];
        tick();
        idle(); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_early_valid: got %0b expected 0", out_valid); end
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = r[0];
        tick();
        idle(); #1;
        checks++; if (out_valid !== 1'b1 || tag !== 8'h10 || result !== r[0]) begin
            errors++; $display("FAIL order_first: got v=%0b tag=%0h res=%0h expected v=1 tag=10 res=%0h", out_valid, tag, result, r[0]);
        end
        cpl_valid = 1; cpl_id = 3'd1; cpl_result = r[1]; out_ready = 1;
        tick();
        cpl_valid = 0; #1;
        checks++; if (out_valid !== 1'b1 || tag !== 8'h11 || result !== r[1]) begin
            errors++; $display("FAIL order_second: got v=%0b tag=%0h res=%0h expected v=1 tag=11 res=%0h", out_valid, tag, result, r[1]);
        end
        tick(); #1;
        checks++; if (out_valid !== 1'b1 || tag !== 8'h12 || result !== r[2]) begin
            errors++; $display("FAIL order_third: got v=%0b tag=%0h res=%0h expected v=1 tag=12 res=%0h", out_valid, tag, result, r[2]);
        end
        tick();
        idle(); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL order_drained: got v=%0b busy=%0b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_full_wrap();
        do_flush();
        for (int i = 0; i < D; i++) begin
            alloc_valid = 1;
            alloc_tag   = 8'(i);
            #1;
            checks++; if (alloc_ready !== 1'b1 || alloc_id !== 3'(i)) begin
                errors++; $display("FAIL fill_alloc: got rdy=%0b id=%0d expected rdy=1 id=%0d", alloc_ready, alloc_id, i);
            end
            tick();
        end
        idle(); #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", alloc_ready); end
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = 64'h1234;
        tick();
        idle();
        out_ready = 1; alloc_valid = 1; alloc_tag = 8'hAA;
        #1;
        checks++; if (out_valid !== 1'b1 || alloc_ready !== 1'b0) begin
            errors++; $display("FAIL full_retire_cycle: got v=%0b rdy=%0b expected v=1 rdy=0", out_valid, alloc_ready);
        end
        tick();
        out_ready = 0; #1;
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd0) begin
            errors++; $display("FAIL wrap_alloc: got rdy=%0b id=%0d expected rdy=1 id=0", alloc_ready, alloc_id);
        end
        tick();
        idle(); #1;
        checks++; if (alloc_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL refull: got rdy=%0b busy=%0b expected 0/1", alloc_ready, busy);
        end
        do_flush();
    endtask

    task automatic test_errors();
        logic [W-1:0] r0;
        r0 = {$urandom, $urandom};
        do_flush();
        alloc_valid = 1; tick(); tick();
        idle();
        cpl_valid = 1; cpl_id = 3'd5; cpl_result = 64'hDEAD;
        tick();
        idle(); #1;
        checks++; if (cpl_err !== 1'b1) begin errors++; $display("FAIL err_unalloc: got %0b expected 1", cpl_err); end
        checks++; if (alloc_id !== 3'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL err_state: got id=%0d busy=%0b v=%0b expected 2/1/0", alloc_id, busy, out_valid);
        end
        tick(); #1;
        checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %0b expected 0", cpl_err); end
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = r0;
        tick();
        cpl_result = ~r0; #1;
        checks++; if (cpl_err !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL first_cpl: got err=%0b v=%0b expected 0/1", cpl_err, out_valid);
        end
        tick();
        idle(); #1;
        checks++; if (cpl_err !== 1'b1) begin errors++; $display("FAIL err_double: got %0b expected 1", cpl_err); end
        checks++; if (result !== r0) begin errors++; $display("FAIL double_kept: got %0h expected %0h", result, r0); end
        tick(); #1;
        checks++; if (cpl_err !== 1'b0) begin errors++; $display("FAIL err_double_len: got %0b expected 0", cpl_err); end
        do_flush();
    endtask

    task automatic test_stall();
        logic [W-1:0] rs;
        rs = {$urandom, $urandom};
        do_flush();
        alloc_valid = 1; tick(); tick();
        idle();
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = rs;
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || result !== rs) begin
                errors++; $display("FAIL stall_hold%0d: got v=%0b res=%0h expected v=1 res=%0h", c, out_valid, result, rs);
            end
            tick();
        end
        out_ready = 1;
        tick();
        idle(); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_release: got v=%0b busy=%0b expected 0/1", out_valid, busy);
        end
        do_flush();
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1;
            tick();
        end
        idle();
        flush = 1; alloc_valid = 1; out_ready = 1;
        cpl_valid = 1; cpl_id = 3'd7; cpl_result = 64'h55;
        tick();
        idle(); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || cpl_err !== 1'b0 || alloc_id !== 3'd0) begin
            errors++; $display("FAIL flush_state: got busy=%0b v=%0b err=%0b id=%0d expected 0/0/0/0", busy, out_valid, cpl_err, alloc_id);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        alloc_valid = 1; tick(); tick(); tick();
        idle();
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = 64'h77;
        tick();
        idle(); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0b expected 1", out_valid); end
        rst = 1; #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || alloc_id !== 3'd0 || result !== '0) begin
            errors++; $display("FAIL mid_reset: got v=%0b busy=%0b id=%0d res=%0h expected 0/0/0/0", out_valid, busy, alloc_id, result);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        tick(); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset: got v=%0b busy=%0b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_random();
        bit            exp_v;
        logic [W-1:0]  exp_r;
        logic [TW-1:0] exp_t;
        logic [4:0]    exp_s;
        logic          exp_e;
        do_flush();
        for (int n = 0; n < 600; n++) begin
            flush       = ($urandom % 64) == 0;
            alloc_valid = ($urandom % 3) != 0;
            alloc_tag   = 8'($urandom);
            out_ready   = ($urandom % 2) != 0;
            cpl_valid   = ($urandom % 2) != 0;
            if (mq.size() > 0 && ($urandom % 4) != 0)
                cpl_id = 3'(mq[$urandom % mq.size()].id);
            else
                cpl_id = 3'($urandom);
            cpl_result = {$urandom, $urandom};
            cpl_status = status_t'(5'($urandom));
            cpl_ext    = 1'($urandom);
            #1;
            exp_v = 0; exp_r = '0; exp_t = '0; exp_s = '0; exp_e = 0;
            if (mq.size() > 0) begin
                exp_t = mq[0].tag;
                if (mq[0].done) begin
                    exp_v = 1; exp_r = mq[0].res; exp_s = mq[0].st; exp_e = mq[0].ext;
                end
`ifdef FPNEW_REORDER_BYPASS_EN
                else if (cpl_valid && int'(cpl_id) == mq[0].id) begin
                    exp_v = 1; exp_r = cpl_result; exp_s = cpl_status; exp_e = cpl_ext;
                end
`endif
            end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_out_valid@%0d: got %0b expected %0b", n, out_valid, exp_v); end
            checks++; if (alloc_ready !== (mq.size() < D)) begin errors++; $display("FAIL rnd_alloc_ready@%0d: got %0b expected %0b", n, alloc_ready, mq.size() < D); end
            checks++; if (alloc_id !== 3'(m_next)) begin errors++; $display("FAIL rnd_alloc_id@%0d: got %0d expected %0d", n, alloc_id, m_next); end
            checks++; if (busy !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %0b expected %0b", n, busy, mq.size() != 0); end
            checks++; if (cpl_err !== m_err) begin errors++; $display("FAIL rnd_cpl_err@%0d: got %0b expected %0b", n, cpl_err, m_err); end
            if (exp_v) begin
                checks++; if (result !== exp_r || tag !== exp_t || status !== exp_s || ext_bit !== exp_e) begin
                    errors++; $display("FAIL rnd_payload@%0d: got %0h/%0h/%0h/%0b expected %0h/%0h/%0h/%0b",
                                       n, result, tag, status, ext_bit, exp_r, exp_t, exp_s, exp_e);
                end
            end
            tick();
        end
        idle();
    endtask

`ifdef FPNEW_REORDER_BYPASS_EN
    task automatic test_bypass();
        logic [W-1:0] rb;
        rb = {$urandom, $urandom};
        do_flush();
        alloc_valid = 1; tick();
        idle();
        cpl_valid = 1; cpl_id = 3'd0; cpl_result = rb; out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b1 || result !== rb) begin
            errors++; $display("FAIL bypass_same_cycle: got v=%0b res=%0h expected v=1 res=%0h", out_valid, result, rb);
        end
        tick();
        idle(); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_retired: got busy=%0b v=%0b expected 0/0", busy, out_valid);
        end
    endtask
`endif

    initial begin
        rst = 1;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 0;
        @(negedge clk);
        test_in_order();
        test_full_wrap();
        test_errors();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef FPNEW_REORDER_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpnew_result_reorder.md
FPNEW_RESULT_REORDER -- requirements
Module: fpnew_result_reorder

Interface
REQ-001 Width SHALL be a parameter, default 64: result width in bits.
REQ-002 Depth SHALL be a parameter, default 8, power of two >= 2: number of reorder slots.
REQ-003 TagWidth SHALL be a parameter, default 8: width of the user tag carried per operation.
REQ-004 clk_i SHALL be an input, 1 bit: the single clock.
REQ-005 rst_i SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 flush_i SHALL be an input, 1 bit: discards all slots.
REQ-007 alloc_valid_i / alloc_ready_o SHALL be input / output, 1 bit each: issue-side slot request handshake.
REQ-008 alloc_tag_i SHALL be an input, TagWidth bits: user tag stored at allocation.
REQ-009 alloc_id_o SHALL be an output, log2(Depth) bits: slot index granted; valid while alloc_ready_o is high.
REQ-010 cpl_valid_i SHALL be an input, 1 bit: completion from an opgroup block.
REQ-011 cpl_id_i SHALL be an input, log2(Depth) bits: index of the completing slot.
REQ-012 cpl_result_i, cpl_status_i, cpl_ext_i SHALL be inputs of Width bits, fpnew_pkg::status_t, and 1 bit: completion payload.
REQ-013 cpl_err_o SHALL be an output, 1 bit: one-cycle pulse when a completion is illegal.
REQ-014 out_valid_o / out_ready_i SHALL be output / input, 1 bit each: in-order retire handshake.
REQ-015 result_o, status_o, extension_bit_o, tag_o SHALL be outputs of Width bits, status_t, 1 bit, and TagWidth bits: head-slot payload.
REQ-016 busy_o SHALL be an output, 1 bit: high while any slot is allocated.

Function
REQ-017 Slots SHALL be allocated circularly from tail_ptr and retired circularly from head_ptr; both pointers wrap modulo Depth.
REQ-018 Occupancy count SHALL range 0..Depth; alloc_ready_o = (count < Depth), with no same-cycle credit from a retire when full.
REQ-019 An alloc handshake SHALL mark slot tail_ptr allocated/not-done, store alloc_tag_i, and increment tail_ptr.
REQ-020 A completion SHALL write the payload into slot cpl_id_i and set its done bit on the next edge.
REQ-021 A completion to an unallocated slot or an already-done slot SHALL be dropped, and cpl_err_o SHALL pulse high the following cycle.
REQ-022 out_valid_o SHALL equal the allocated and done bits of slot head_ptr; the payload outputs SHALL show that slot.
REQ-023 An out handshake SHALL clear slot head_ptr and increment head_ptr.
REQ-024 Simultaneous alloc and retire SHALL leave count unchanged.
REQ-025 A completion and its retire in the same cycle to different slots SHALL both take effect.
REQ-026 Without bypass, latency from completion to out_valid_o SHALL be 1 cycle.
REQ-027 out_valid_o SHALL stay asserted with a stable payload until out_ready_i is high.
REQ-028 flush_i SHALL clear all allocated/done bits, zero both pointers and count on the next edge, and take priority over same-cycle alloc, completion and retire.
REQ-029 flush_i SHALL suppress cpl_err_o for that cycle.
REQ-030 busy_o SHALL be (count != 0).

Reset
REQ-031 While rst_i is high, all slot state, pointers and count SHALL be zero.
REQ-032 While rst_i is high, outputs SHALL read alloc_ready_o=1, alloc_id_o=0, out_valid_o=0, cpl_err_o=0, busy_o=0, result_o/status_o/extension_bit_o/tag_o=0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight slots without emitting them.

Configuration
REQ-034 With FPNEW_REORDER_BYPASS_EN defined, a valid completion to head_ptr while that slot is allocated and not done SHALL drive out_valid_o and the payload combinationally in the same cycle.
REQ-035 If that bypassed completion is accepted by out_ready_i, the slot SHALL retire without being written; otherwise it SHALL be stored normally.
REQ-036 Without FPNEW_REORDER_BYPASS_EN, no combinational path SHALL exist from the cpl_* inputs to any output.

Structure
REQ-037 The per-slot entry typedef (result, status, ext_bit, tag, allocated, done) SHALL reside in fpnew_pkg, alongside the existing status_t.
REQ-038 No sub-module is required; pointers and storage SHALL be implemented inline.

Verification
REQ-039 Allocate 3 ops (tags 0x10/0x11/0x12, ids 0/1/2), complete ids 2,0,1 -> retire order tags 0x10,0x11,0x12, each 1 cycle after the enabling completion.
REQ-040 Allocate 8 with no retire -> alloc_ready_o=0; retire one while alloc_valid_i=1 -> no alloc that cycle, alloc next cycle with id 0 (wrap).
REQ-041 Complete id 5 while unallocated -> cpl_err_o pulses for 1 cycle, state unchanged; complete an allocated id twice -> second completion pulses cpl_err_o.
REQ-042 Hold out_ready_i=0 for 4 cycles with head done -> out_valid_o and result_o stable for all 4 cycles.
REQ-043 Assert flush_i with 5 slots allocated plus a same-cycle completion -> next cycle busy_o=0, out_valid_o=0, cpl_err_o=0, next alloc_id_o=0.
REQ-044 With FPNEW_REORDER_BYPASS_EN, head completion with out_ready_i=1 -> out_valid_o in the same cycle and count decrements at the next edge.
